// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline defines for hazard control
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } hz_state_e;

    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF   = 16;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush control with memory-timeout fault
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    hz_state_e  state, state_next;
    logic [7:0] wait_cnt;
    logic       mem_stall;
    logic       load_use;

    assign mem_stall = dmem_req_i && !dmem_ready_i && (state != ST_FAULT);
    assign load_use  = load_use_hit(idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i);
    assign fault_o   = (state == ST_FAULT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (state == ST_RUN && state_next == ST_MEM_WAIT) begin
                wait_cnt <= 8'd0;
            end else if (state == ST_MEM_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:      if (mem_stall) state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_next = ST_RUN;
                end else if (wait_cnt == TIMEOUT_W) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT:    state_next = ST_FAULT;
            default:     state_next = ST_RUN;
        endcase
    end

    // Priority: reset drain > fault > memory stall > load-use > branch
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (state == ST_FAULT) begin
            pc_write_o    = 1'b0;
            ifid_stall_o  = 1'b1;
            pipe_freeze_o = 1'b1;
        end else if (mem_stall) begin
            pc_write_o    = 1'b0;
            ifid_stall_o  = 1'b1;
            pipe_freeze_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!pc_write_o && (state != ST_FAULT)),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ifid_flush_o && !rst_i),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    // ctl field order: {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fault}
    localparam logic [5:0] C_RST  = 6'b001100;
    localparam logic [5:0] C_RSTF = 6'b001101;
    localparam logic [5:0] C_IDLE = 6'b100000;
    localparam logic [5:0] C_LU   = 6'b010100;
    localparam logic [5:0] C_BR   = 6'b101000;
    localparam logic [5:0] C_MEM  = 6'b010010;
    localparam logic [5:0] C_FLT  = 6'b010011;

    typedef struct {
        string      name;
        logic [5:0] ctl;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       memread = 1'b0;
    logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic       br = 1'b0, req = 1'b0, rdy = 1'b0;
    logic       pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fault;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memread_i (memread),
        .idex_rd_i      (rd),
        .ifid_rs1_i     (rs1),
        .ifid_rs2_i     (rs2),
        .branch_taken_i (br),
        .dmem_req_i     (req),
        .dmem_ready_i   (rdy),
        .pc_write_o     (pc_write),
        .ifid_stall_o   (ifid_stall),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .pipe_freeze_o  (pipe_freeze),
        .fault_o        (fault),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    task automatic step(input string name, input logic r, input logic mr,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic b, input logic rq, input logic ry,
                        input logic [5:0] ctl, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; memread = mr; rd = d; rs1 = s1; rs2 = s2;
        br = b; req = rq; rdy = ry;
        e.name = name;
        e.ctl  = ctl;
        e.sc   = 4'(sc);
        e.fc   = 4'(fc);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [5:0] got;
            e   = q.pop_front();
            got = {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fault};
            total++;
            if (got !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                bad++;
                $display("FAIL %s: got ctl=%b sc=%0d fc=%0d, need ctl=%b sc=%0d fc=%0d",
                         e.name, got, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        int waited;
        step("reset",        1, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
        step("loaduse_rs2",  0, 1, 5, 0, 5, 0, 0, 0, C_LU,   0, 0);
        step("after_lu",     0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0);
        step("x0_filter",    0, 1, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0);
        step("branch",       0, 0, 0, 0, 0, 1, 0, 0, C_BR,   1, 0);
        step("branch_lu",    0, 1, 7, 7, 0, 1, 0, 0, C_LU,   1, 1);
        step("idle2",        0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 2, 1);
        step("mem_over_lu",  0, 1, 3, 3, 0, 1, 1, 0, C_MEM,  2, 1);
        step("mem_wait1",    0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  3, 1);
        step("mem_wait2",    0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  4, 1);
        step("mem_ready",    0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 5, 1);
        step("run_again",    0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 5, 1);
        step("reset2",       1, 0, 0, 0, 0, 0, 0, 0, C_RST,  5, 1);
        step("to_wait",      0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  0, 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("wait_%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, i + 1, 0);
        step("fault_ignore", 0, 1, 2, 2, 0, 1, 0, 0, C_FLT,  6, 0);
        step("fault_ready",  0, 0, 0, 0, 0, 0, 1, 1, C_FLT,  6, 0);
        step("fault_reset",  1, 0, 0, 0, 0, 0, 0, 0, C_RSTF, 6, 0);
        step("post_fault",   0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
        for (int i = 0; i < 20; i++)
            step($sformatf("sat_%0d", i), 0, 1, 9, 9, 9, 0, 0, 0, C_LU, (i > 15) ? 15 : i, 0);
        step("sat_hold",     0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 15, 0);
        step("reset3",       1, 0, 0, 0, 0, 0, 0, 0, C_RST,  15, 0);
        step("wait_enter",   0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  0, 0);
        step("wait_mid",     0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 0);
        step("reset_in_wait",1, 0, 0, 0, 0, 0, 1, 0, C_RST,  2, 0);
        step("after_rst_mw", 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
        step("branch2",      0, 0, 0, 0, 0, 1, 0, 0, C_BR,   0, 0);
        step("after_br2",    0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 1);
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum MEM_WAIT cycles before a fault is declared.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 Port clk_i  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port idex_memread_i  in  1  the instruction in ID/EX is a load.
REQ-006 Port idex_rd_i  in  5  destination register of the instruction in ID/EX.
REQ-007 Port ifid_rs1_i, ifid_rs2_i  in  5 each  source registers of the instruction in IF/ID.
REQ-008 Port branch_taken_i  in  1  the ID-stage branch compare resolved taken.
REQ-009 Port dmem_req_i  in  1  the instruction in EX/MEM is accessing data memory (load or store).
REQ-010 Port dmem_ready_i  in  1  data memory completes the access this cycle.
REQ-011 Port pc_write_o  out  1  PC update enable.
REQ-012 Port ifid_stall_o  out  1  IF/ID hold.
REQ-013 Port ifid_flush_o  out  1  zero the IF/ID instruction.
REQ-014 Port idex_bubble_o  out  1  inject NOP control into ID/EX.
REQ-015 Port pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 Port fault_o  out  1  sticky memory-timeout fault.
REQ-017 Port stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating performance counters.

Function
REQ-018 The FSM SHALL have states RUN, MEM_WAIT and FAULT.
REQ-019 RUN SHALL go to MEM_WAIT when dmem_req_i=1 and dmem_ready_i=0.
REQ-020 MEM_WAIT SHALL go to RUN on dmem_ready_i=1.
REQ-021 MEM_WAIT SHALL go to FAULT when its wait counter reaches TIMEOUT and dmem_ready_i=0 in that cycle.
REQ-022 FAULT SHALL be left only by reset.
REQ-023 The wait counter SHALL be 8-bit, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, and held otherwise.
REQ-024 Memory stall SHALL be active when dmem_req_i=1 and dmem_ready_i=0, in RUN or MEM_WAIT, in the same cycle (combinational).
REQ-025 Memory stall SHALL drive pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1, ifid_flush_o=0 and idex_bubble_o=0.
REQ-026 Load-use SHALL be detected when idex_memread_i=1, idex_rd_i!=0, and idex_rd_i equals ifid_rs1_i or ifid_rs2_i.
REQ-027 Load-use, when memory stall is inactive, SHALL drive pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1 and ifid_flush_o=0.
REQ-028 Branch flush SHALL occur when branch_taken_i=1 with neither memory stall nor load-use active, driving ifid_flush_o=1 and pc_write_o=1.
REQ-029 A taken branch during a stall SHALL be ignored; the ID stage re-evaluates it after the stall.
REQ-030 Priority SHALL be FAULT > memory stall > load-use > branch.
REQ-031 With no condition active, outputs SHALL be pc_write_o=1 and all other control outputs 0.
REQ-032 In FAULT, outputs SHALL be pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1 and fault_o=1, and all inputs SHALL be ignored.
REQ-033 stall_cnt_o SHALL increment once per cycle in which pc_write_o=0 outside FAULT.
REQ-034 flush_cnt_o SHALL increment once per ifid_flush_o=1 cycle outside reset.
REQ-035 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-036 When rst_i=1 at a clock edge, the FSM SHALL go to RUN, the wait counter SHALL clear, stall_cnt_o and flush_cnt_o SHALL clear to 0, and fault_o SHALL clear to 0.
REQ-037 While rst_i=1, outputs SHALL be pc_write_o=0, ifid_flush_o=1, idex_bubble_o=1, ifid_stall_o=0 and pipe_freeze_o=0, so that the pipeline drains to NOPs.
REQ-038 Reset asserted during MEM_WAIT or FAULT SHALL take effect at the next edge, with no pending state retained.

Structure
REQ-039 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2), the default TIMEOUT and the default CNT_W SHALL live in the shared opcodes/defines header used by the pipeline.
REQ-040 The saturating counter SHALL be a sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice.
REQ-041 All stall/flush outputs SHALL be combinational from state and inputs; only the FSM, the wait counter and the performance counters SHALL be registers.

Verification
REQ-042 Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 for one cycle -> pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, stall_cnt_o=1 after the edge.
REQ-043 x0 filter: idex_memread_i=1, idex_rd_i=0, ifid_rs1_i=0 -> no stall, pc_write_o=1.
REQ-044 Branch: branch_taken_i=1 with no hazard -> ifid_flush_o=1 for that cycle and flush_cnt_o=1; branch_taken_i=1 together with load-use -> ifid_flush_o=0.
REQ-045 Memory wait: dmem_req_i=1 and dmem_ready_i=0 for 3 cycles, then ready=1 -> pipe_freeze_o=1 for 3 cycles, state back to RUN, stall_cnt_o=3.
REQ-046 Timeout with TIMEOUT=4: ready held 0 -> FAULT with fault_o=1 after the 5th wait cycle; outputs stay frozen; a 1-cycle rst_i pulse -> RUN, fault_o=0, counters 0.
REQ-047 Saturation with CNT_W=4: 20 load-use cycles -> stall_cnt_o=15.
